// File: rtl/parallel_input_ctrl_pkg.sv
// Shared definitions for the parallel input controller: bus encodings,
// status register layout and the device handshake state type.
package parallel_input_ctrl_pkg;

  localparam logic [1:0] RW_READ  = 2'b10;
  localparam logic [1:0] RW_WRITE = 2'b11;

  localparam logic ADDR_SR = 1'b0;
  localparam logic ADDR_BR = 1'b1;

  localparam int SR_RDY  = 7;
  localparam int SR_FULL = 6;
  localparam int SR_IE   = 0;

  typedef enum logic [1:0] {
    DEV_IDLE    = 2'd0,
    DEV_CAPTURE = 2'd1,
    DEV_ACK     = 2'd2
  } dev_state_t;

  function automatic logic [7:0] make_sr(input logic rdy, input logic full, input logic ie);
    logic [7:0] sr;
    sr          = 8'h00;
    sr[SR_RDY]  = rdy;
    sr[SR_FULL] = full;
    sr[SR_IE]   = ie;
    return sr;
  endfunction

endpackage

// File: rtl/parallel_input_ctrl_if.sv
// CPU register bus and device strobe/acknowledge signals of the controller.
interface parallel_input_ctrl_if;
  logic [1:0] RW;
  logic       ADDR;
  logic [7:0] Din;
  logic [7:0] Dout;
  logic       IRQ;
  logic [7:0] PD;
  logic       STB;
  logic       ACK;

  modport master (
    output RW, ADDR, Din, PD, STB,
    input  Dout, IRQ, ACK
  );

  modport slave (
    input  RW, ADDR, Din, PD, STB,
    output Dout, IRQ, ACK
  );
endinterface

// File: rtl/parallel_input_ctrl_pic_fifo.sv
// Synchronous receive FIFO with flush; flush overrides push and pop.
// The head entry is presented combinationally for the register read path.
module pic_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign count   = cnt;
  assign head    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/parallel_input_ctrl.sv
// Parallel input controller: captures device bytes over a strobe/ack
// handshake into a FIFO and presents them to the CPU via SR/BR registers.
module parallel_input_ctrl
  import parallel_input_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic                   CLK,
  input logic                   RSTn,
  parallel_input_ctrl_if.slave  bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          stb_meta;
  logic          s_stb;
  dev_state_t    state;
  logic          ack_q;
  logic          ie;
  logic          irq_q;
  logic [7:0]    dout_q;

  logic          push;
  logic          pop;
  logic          flush;
  logic          full;
  logic          empty;
  logic [7:0]    head;
  logic [CW-1:0] count;
  logic          cpu_read;
  logic          cpu_write;
  logic [7:0]    sr;
  logic          unused_din;

  assign cpu_read   = (bus.RW == RW_READ);
  assign cpu_write  = (bus.RW == RW_WRITE);
  assign sr         = make_sr(count != '0, count == CW'(DEPTH), ie);
  assign pop        = cpu_read && (bus.ADDR == ADDR_BR) && !empty;
  assign flush      = cpu_write && (bus.ADDR == ADDR_SR) && bus.Din[1];
  assign push       = (state == DEV_CAPTURE);
  assign unused_din = ^bus.Din[7:2];

  assign bus.ACK  = ack_q;
  assign bus.IRQ  = irq_q;
  assign bus.Dout = dout_q;

  pic_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RSTn),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (bus.PD),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // STB comes from the device clock domain.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      stb_meta <= 1'b0;
      s_stb    <= 1'b0;
    end else begin
      stb_meta <= bus.STB;
      s_stb    <= stb_meta;
    end
  end

  // A strobe seen while full simply waits in IDLE, which is the backpressure.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state <= DEV_IDLE;
      ack_q <= 1'b0;
    end else begin
      case (state)
        DEV_IDLE: begin
          if (s_stb && !full) state <= DEV_CAPTURE;
        end
        DEV_CAPTURE: begin
          state <= DEV_ACK;
          ack_q <= 1'b1;
        end
        DEV_ACK: begin
          if (!s_stb) begin
            state <= DEV_IDLE;
            ack_q <= 1'b0;
          end
        end
        default: begin
          state <= DEV_IDLE;
          ack_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      ie     <= 1'b0;
      dout_q <= 8'h00;
      irq_q  <= 1'b1;
    end else begin
      if (cpu_write && (bus.ADDR == ADDR_SR)) ie <= bus.Din[SR_IE];
      if (cpu_read) begin
        if (bus.ADDR == ADDR_SR) dout_q <= sr;
        else                     dout_q <= empty ? 8'h00 : head;
      end
      irq_q <= ~(ie & sr[SR_RDY]);
    end
  end

endmodule
